// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: pattern modes, default
// 800x600@60 timing and the axis-total helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_CHECK = 2'd3
    } vga_mode_e;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;
    localparam int DEF_COUNT_W   = 11;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus sync and visible-region
// decode. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK,
    parameter bit POS     = 1'b1,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               step,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync_active,
    output logic               visible
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_FIRST = COUNT_W'(VISIBLE + FRONT);
    localparam logic [COUNT_W-1:0] SYNC_LAST  = COUNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [COUNT_W-1:0] VIS_END    = COUNT_W'(VISIBLE);

    if (TOTAL > (1 << COUNT_W)) begin : g_total_check
        $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, COUNT_W);
    end

    assign wrap    = (count == LAST);
    assign visible = (count < VIS_END);

    // sync_active is delivered at pin polarity, ready to register
    always_comb begin
        sync_active = ~POS;
        if ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) begin
            sync_active = POS;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (step && en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-strobe divider, H/V timing,
// frame-latched pattern mode and the registered colour/sync output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit HSYNC_POS   = 1'b1,
    parameter bit VSYNC_POS   = 1'b1,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int COLOR_W     = 4,
    parameter int GRAD_SHIFT  = 5,
    parameter int BAND_SHIFT  = 6,
    parameter int CHECK_SHIFT = 5
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [1:0]           mode_sel,
    input  logic [3*COLOR_W-1:0] ext_rgb,
    output logic                 pix_tick,
    output logic [COUNT_W-1:0]   hpos,
    output logic [COUNT_W-1:0]   vpos,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 h_wrap, v_wrap;
    logic                 h_sync_lvl, v_sync_lvl;
    logic                 h_vis, v_vis;
    logic                 line_px, frame_px;
    vga_mode_e            mode_q, mode_eff;
    logic [3*COLOR_W-1:0] solid_q, solid_eff, rgb_next, rgb_q;
    logic [COLOR_W-1:0]   grad;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POS(HSYNC_POS), .COUNT_W(COUNT_W)
    ) u_h_axis (
        .clk(clk), .nrst(nrst), .step(tick), .en(1'b1),
        .count(hpos), .wrap(h_wrap), .sync_active(h_sync_lvl), .visible(h_vis)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POS(VSYNC_POS), .COUNT_W(COUNT_W)
    ) u_v_axis (
        .clk(clk), .nrst(nrst), .step(tick), .en(h_wrap),
        .count(vpos), .wrap(v_wrap), .sync_active(v_sync_lvl), .visible(v_vis)
    );

    // Origin flags track hpos==0 / (hpos,vpos)==(0,0) from the wrap decodes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            line_px  <= 1'b1;
            frame_px <= 1'b1;
        end else if (tick) begin
            line_px  <= h_wrap;
            frame_px <= h_wrap && v_wrap;
        end
    end

    // The first pixel of a frame already uses the mode/colour sampled on it
    assign mode_eff  = frame_px ? vga_mode_e'(mode_sel) : mode_q;
    assign solid_eff = frame_px ? ext_rgb : solid_q;
    assign grad      = hpos[GRAD_SHIFT +: COLOR_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q  <= MODE_EXT;
            solid_q <= '0;
        end else if (tick && frame_px) begin
            mode_q  <= mode_eff;
            solid_q <= ext_rgb;
        end
    end

    always_comb begin
        rgb_next = '0;
        if (h_vis && v_vis) begin
            case (mode_eff)
                MODE_EXT:   rgb_next = ext_rgb;
                MODE_GRAD:  rgb_next = {grad & {COLOR_W{vpos[BAND_SHIFT+2]}},
                                        grad & {COLOR_W{vpos[BAND_SHIFT+1]}},
                                        grad & {COLOR_W{vpos[BAND_SHIFT]}}};
                MODE_SOLID: rgb_next = solid_eff;
                MODE_CHECK: rgb_next = {(3*COLOR_W){hpos[CHECK_SHIFT] ^ vpos[CHECK_SHIFT]}};
                default:    rgb_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_POS;
            vsync       <= ~VSYNC_POS;
            de          <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pix_tick    <= tick;
            line_start  <= tick && line_px;
            frame_start <= tick && frame_px;
            if (tick) begin
                hsync <= h_sync_lvl;
                vsync <= v_sync_lvl;
                de    <= h_vis && v_vis;
                rgb_q <= rgb_next;
            end
        end
    end

    assign red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small timing config: a position
// model predicts each pixel's outputs, a monitor pops and compares per pix_tick.
module tb_vga_timing_gen;

    localparam int CLK_DIV = 2;
    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int CW = 5, COLW = 4, GS = 0, BS = 0, CS = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * CLK_DIV;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [1:0]    mode_sel = 2'd0;
    logic [11:0]   ext_rgb = 12'h000;
    logic          pix_tick, line_start, frame_start, hsync, vsync, de;
    logic [CW-1:0] hpos, vpos;
    logic [3:0]    red, green, blue;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POS(HPOL), .VSYNC_POS(VPOL), .COUNT_W(CW), .COLOR_W(COLW),
        .GRAD_SHIFT(GS), .BAND_SHIFT(BS), .CHECK_SHIFT(CS)
    ) dut (
        .clk(clk), .nrst(nrst), .mode_sel(mode_sel), .ext_rgb(ext_rgb),
        .pix_tick(pix_tick), .hpos(hpos), .vpos(vpos),
        .line_start(line_start), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs, vs, de, ls, fs;
        logic [11:0]   rgb;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          mh = 0, mv = 0;
    int          fmode = 0;
    logic [11:0] fsolid = 12'h000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the outputs of the pixel at model position (mh,mv)
    task automatic push_expected();
        exp_t e;
        int   g, r, gr, b;
        bit   hs_act, vs_act;
        if (mh == 0 && mv == 0) begin
            fmode  = int'(mode_sel);
            fsolid = ext_rgb;
        end
        e.ls   = (mh == 0);
        e.fs   = (mh == 0 && mv == 0);
        hs_act = (mh >= HV + HF) && (mh < HV + HF + HS);
        vs_act = (mv >= VV + VF) && (mv < VV + VF + VS);
        e.hs   = hs_act ? HPOL : !HPOL;
        e.vs   = vs_act ? VPOL : !VPOL;
        e.de   = (mh < HV) && (mv < VV);
        e.rgb  = 12'h000;
        if (e.de) begin
            case (fmode)
                0: e.rgb = ext_rgb;
                1: begin
                    g  = (mh >> GS) % 16;
                    r  = ((mv >> (BS + 2)) % 2 == 1) ? g : 0;
                    gr = ((mv >> (BS + 1)) % 2 == 1) ? g : 0;
                    b  = ((mv >> BS) % 2 == 1) ? g : 0;
                    e.rgb = 12'(r * 256 + gr * 16 + b);
                end
                2: e.rgb = fsolid;
                default: e.rgb = ((((mh >> CS) ^ (mv >> CS)) % 2) == 1) ? 12'hFFF : 12'h000;
            endcase
        end
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv + 1) % VT;
        end else begin
            mh = mh + 1;
        end
        e.h = CW'(mh);
        e.v = CW'(mv);
        q.push_back(e);
    endtask

    // Called at a negedge; drives inputs for the coming edge and returns at the next negedge
    task automatic step(input bit rand_mode);
        ext_rgb = 12'($urandom);
        if (rand_mode && $urandom_range(0, 39) == 0) mode_sel = 2'($urandom);
        if (edge_cnt % CLK_DIV == 0) push_expected();
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic drive(input int n, input bit rand_mode);
        for (int i = 0; i < n; i++) step(rand_mode);
    endtask

    task automatic drive_until(input int th, input int tv);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            if (edge_cnt % CLK_DIV == 1 && mh == th && mv == tv) begin
                found = 1'b1;
                break;
            end
            step(1'b0);
        end
        check("reach_position", int'(found), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pix_tick"}, int'(pix_tick), 0);
        check({tag, "_hpos"}, int'(hpos), 0);
        check({tag, "_vpos"}, int'(vpos), 0);
        check({tag, "_de"}, int'(de), 0);
        check({tag, "_rgb"}, int'({red, green, blue}), 0);
        check({tag, "_hsync"}, int'(hsync), int'(!HPOL));
        check({tag, "_vsync"}, int'(vsync), int'(!VPOL));
        check({tag, "_line_start"}, int'(line_start), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (pix_tick) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: pix_tick high with nothing predicted (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                check("hpos", int'(hpos), int'(e.h));
                check("vpos", int'(vpos), int'(e.v));
                check("hsync", int'(hsync), int'(e.hs));
                check("vsync", int'(vsync), int'(e.vs));
                check("de", int'(de), int'(e.de));
                check("line_start", int'(line_start), int'(e.ls));
                check("frame_start", int'(frame_start), int'(e.fs));
                check("rgb", int'({red, green, blue}), int'(e.rgb));
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset_state("por");
        nrst = 1'b1;

        mode_sel = 2'd3;
        drive(2 * FRAME_CLK, 1'b0);

        mode_sel = 2'd1;
        drive(FRAME_CLK + 6, 1'b0);
        drive_until(3, 2);
        mode_sel = 2'd2;
        drive(2 * FRAME_CLK, 1'b0);

        mode_sel = 2'd0;
        drive(2 * FRAME_CLK, 1'b0);

        drive(8 * FRAME_CLK, 1'b1);

        drive_until(5, 3);
        #2 nrst = 1'b0;
        #1 check_reset_state("midframe");
        q.delete();
        @(negedge clk);
        nrst = 1'b1;
        mh = 0;
        mv = 0;
        edge_cnt = 0;
        drive(2 * FRAME_CLK, 1'b1);

        #2 check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
